// File: rtl/nbit_4x1_multiplexer.sv
// N-bit 4:1 mux: combinational Y plus a clocked capture of word, select and a saturating select-change count.
// Latency: Y is zero-latency; Y_q/S_q/valid_q/sel_changes update one clk after en=1.
// No backpressure: capture happens on every enabled edge. Optional parity_q output under NBIT_MUX_PARITY_EN.
module nbit_4x1_multiplexer #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [N-1:0]     C,
    input  logic [N-1:0]     D,
    input  logic [1:0]       S,
    input  logic             en,
    output logic [N-1:0]     Y,
    output logic [N-1:0]     Y_q,
    output logic [1:0]       S_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] sel_changes
`ifdef NBIT_MUX_PARITY_EN
    ,
    output logic             parity_q
`endif
);

    logic [N-1:0]     y_q, y_d;
    logic [1:0]       s_q, s_d;
    logic             valid_q_r, valid_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An unknown select poisons the whole word so bad selects are visible in simulation.
    always_comb begin
        case (S)
            2'b00:   Y = A;
            2'b01:   Y = B;
            2'b10:   Y = C;
            2'b11:   Y = D;
            default: Y = {N{1'bx}};
        endcase
    end

    always_comb begin
        y_d      = y_q;
        s_d      = s_q;
        valid_d  = 1'b0;
        primed_d = primed_q;
        cnt_d    = cnt_q;
        if (en) begin
            y_d      = Y;
            s_d      = S;
            valid_d  = 1'b1;
            primed_d = 1'b1;
            // The first capture after reset has no prior select to compare against.
            if (primed_q && (S != s_q) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            s_q       <= 2'b00;
            valid_q_r <= 1'b0;
            primed_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            y_q       <= y_d;
            s_q       <= s_d;
            valid_q_r <= valid_d;
            primed_q  <= primed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Y_q         = y_q;
    assign S_q         = s_q;
    assign valid_q     = valid_q_r;
    assign sel_changes = cnt_q;

`ifdef NBIT_MUX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (en) begin
            par_d = ^Y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_q = par_q;
`endif

endmodule

// File: tb/tb_nbit_4x1_multiplexer.sv
// Bench for nbit_4x1_multiplexer: directed plan cases plus random traffic against a word-array reference model.
// Two instances share inputs: default CNT_W=8 and CNT_W=2 to exercise counter saturation.
module tb_nbit_4x1_multiplexer;

    logic       clk = 1'b0;
    bit         clk_run = 1'b0;
    logic       rst_n;
    logic [7:0] A, B, C, D;
    logic [1:0] S;
    logic       en;

    logic [7:0] Y, Y_q, Y2, Y_q2;
    logic [1:0] S_q, S_q2;
    logic       valid_q, valid_q2;
    logic [7:0] sel_changes;
    logic [1:0] sel_changes2;
`ifdef NBIT_MUX_PARITY_EN
    logic       parity_q, parity_q2;
`endif

    nbit_4x1_multiplexer #(.N(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .S(S), .en(en),
        .Y(Y), .Y_q(Y_q), .S_q(S_q), .valid_q(valid_q), .sel_changes(sel_changes)
`ifdef NBIT_MUX_PARITY_EN
        , .parity_q(parity_q)
`endif
    );

    nbit_4x1_multiplexer #(.N(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .S(S), .en(en),
        .Y(Y2), .Y_q(Y_q2), .S_q(S_q2), .valid_q(valid_q2), .sel_changes(sel_changes2)
`ifdef NBIT_MUX_PARITY_EN
        , .parity_q(parity_q2)
`endif
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the four words as an array, the last captured select and plain-integer counters.
    logic [7:0] w [4];
    logic [7:0] m_y;
    logic [1:0] m_s;
    logic       m_v;
    logic       m_par;
    bit         m_primed;
    int         m_cnt;
    int         m_cnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_words();
        A = w[0]; B = w[1]; C = w[2]; D = w[3];
    endtask

    task automatic model_reset();
        m_y = 8'h00; m_s = 2'b00; m_v = 1'b0; m_par = 1'b0;
        m_primed = 1'b0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".Y_q"}, 32'(Y_q), 32'(m_y));
        chk({tag, ".S_q"}, 32'(S_q), 32'(m_s));
        chk({tag, ".valid_q"}, 32'(valid_q), 32'(m_v));
        chk({tag, ".sel_changes"}, 32'(sel_changes), 32'(m_cnt));
        chk({tag, ".Y_q2"}, 32'(Y_q2), 32'(m_y));
        chk({tag, ".sel_changes2"}, 32'(sel_changes2), 32'(m_cnt2));
`ifdef NBIT_MUX_PARITY_EN
        chk({tag, ".parity_q"}, 32'(parity_q), 32'(m_par));
        chk({tag, ".parity_q2"}, 32'(parity_q2), 32'(m_par));
`endif
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".Y"}, 32'(Y), 32'(w[S]));
        chk({tag, ".Y2"}, 32'(Y2), 32'(w[S]));
    endtask

    // One clock: drive inputs away from the edge, check Y, then apply the capture rules to the model.
    task automatic cycle(input string tag, input logic e, input logic [1:0] s);
        en = e; S = s; drive_words();
        #1;
        check_comb(tag);
        @(posedge clk);
        if (e) begin
            if (m_primed && (s != m_s)) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_y = w[s]; m_s = s; m_v = 1'b1; m_primed = 1'b1;
            m_par = ^w[s];
        end else begin
            m_v = 1'b0;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; S = 2'b00;
        w[0] = 8'h55; w[1] = 8'hAA; w[2] = 8'hF0; w[3] = 8'h0F;
        drive_words();
        model_reset();

        // Combinational path with no clock running.
        for (int i = 0; i < 4; i++) begin
            S = 2'(i);
            #1;
            check_comb("noclk");
            #9;
        end

        // Reset held: Y still tracks S, registered outputs at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S = 2'(3 - i);
            #1;
            check_comb("inrst");
            check_regs("inrst");
            #9;
        end

        rst_n = 1'b1;
        #1;
        clk_run = 1'b1;

        // Sequential sweep: three select changes, first capture uncounted.
        for (int i = 0; i < 4; i++) cycle("sweep", 1'b1, 2'(i));

        // en low: registers hold while inputs move.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
            cycle("hold", 1'b0, 2'($urandom_range(0, 3)));
        end

        // Alternate selects to saturate the narrow counter.
        w[0] = 8'h55; w[1] = 8'hAA; w[2] = 8'hF0; w[3] = 8'h0F;
        for (int i = 0; i < 6; i++) cycle("alt", 1'b1, 2'(i % 2));

        // Asynchronous reset mid-cycle.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("midrst");
        #2;
        rst_n = 1'b1;

        // Parity cases, then data-only change with unchanged select.
        cycle("par55", 1'b1, 2'b00);
        cycle("parF0", 1'b1, 2'b10);
        w[0] = 8'h07;
        cycle("par07", 1'b1, 2'b00);
        w[0] = 8'h3C;
        cycle("dataonly", 1'b1, 2'b00);

        // Random traffic, long enough to saturate the 8-bit counter.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
            cycle("rand", ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)));
        end
        chk("saturated", 32'(sel_changes), 32'(m_cnt));

        clk_run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
